// File: rtl/aes_round_ctrl.sv
`timescale 1ns/1ps
// aes_round_ctrl: sequences the AES-128 round stages (SubBytes, ShiftRows,
// MixColumns, AddRoundKey) through a one-cycle enable / done handshake.
// Optional stage watchdog: define AES_CTRL_TIMEOUT_EN to compile it in.
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       g_rst,
    input  logic       start,
    input  logic       abort,
    input  logic       sb_done,
    input  logic       sr_done,
    input  logic       mc_done,
    input  logic       ark_done,
    output logic       sb_en,
    output logic       sr_en,
    output logic       mc_en,
    output logic       ark_en,
    output logic [3:0] round_idx,
    output logic       last_round,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned RW = 4;

    // Elaboration guards on parameter ranges
    if (NUM_ROUNDS == 0 || NUM_ROUNDS > 15) begin : g_rounds_chk
        $error("aes_round_ctrl: NUM_ROUNDS must be 1..15");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_tmo_chk
        $error("aes_round_ctrl: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARK0,
        S_SB,
        S_SR,
        S_MC,
        S_ARK,
        S_FIN
    } state_t;

    state_t state;
    logic   wait_c;
    logic   act_done_c;

    // A stage is waiting once its enable cycle has passed
    assign wait_c = (state inside {S_ARK0, S_SB, S_SR, S_MC, S_ARK}) &&
                    !(ark_en || sb_en || sr_en || mc_en);

    // Select the done flag of the active stage only; others are ignored
    always_comb begin
        act_done_c = 1'b0;
        case (state)
            S_ARK0, S_ARK: act_done_c = ark_done;
            S_SB:          act_done_c = sb_done;
            S_SR:          act_done_c = sr_done;
            S_MC:          act_done_c = mc_done;
            default:       act_done_c = 1'b0;
        endcase
        act_done_c = act_done_c && wait_c;
    end

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit_c;

    assign tmo_hit_c = wait_c && !act_done_c &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Count waiting cycles of the current stage; cleared on every enable cycle
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            tmo_cnt <= '0;
        end else if (!wait_c || abort) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= TMO_W'(tmo_cnt + TMO_W'(1));
        end
    end
`else
    assign err = 1'b0;
`endif

    // Round sequencer with registered enables and status
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            state      <= S_IDLE;
            sb_en      <= 1'b0;
            sr_en      <= 1'b0;
            mc_en      <= 1'b0;
            ark_en     <= 1'b0;
            round_idx  <= '0;
            last_round <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
            err        <= 1'b0;
`endif
        end else begin
            sb_en  <= 1'b0;
            sr_en  <= 1'b0;
            mc_en  <= 1'b0;
            ark_en <= 1'b0;
            done   <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
            err    <= 1'b0;
`endif
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
            end else if (tmo_hit_c) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                err   <= 1'b1;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state      <= S_ARK0;
                            ark_en     <= 1'b1;
                            busy       <= 1'b1;
                            round_idx  <= '0;
                            last_round <= 1'b0;
                        end
                    end
                    S_ARK0: begin
                        if (act_done_c) begin
                            state      <= S_SB;
                            sb_en      <= 1'b1;
                            round_idx  <= RW'(1);
                            last_round <= (NUM_ROUNDS == 1);
                        end
                    end
                    S_SB: begin
                        if (act_done_c) begin
                            state <= S_SR;
                            sr_en <= 1'b1;
                        end
                    end
                    S_SR: begin
                        if (act_done_c) begin
                            if (last_round) begin
                                state  <= S_ARK;
                                ark_en <= 1'b1;
                            end else begin
                                state <= S_MC;
                                mc_en <= 1'b1;
                            end
                        end
                    end
                    S_MC: begin
                        if (act_done_c) begin
                            state  <= S_ARK;
                            ark_en <= 1'b1;
                        end
                    end
                    S_ARK: begin
                        if (act_done_c) begin
                            if (last_round) begin
                                state <= S_FIN;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state      <= S_SB;
                                sb_en      <= 1'b1;
                                round_idx  <= RW'(round_idx + RW'(1));
                                last_round <= (RW'(round_idx + RW'(1)) == RW'(NUM_ROUNDS));
                            end
                        end
                    end
                    S_FIN: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for aes_round_ctrl: stage models reply to enables after a
// programmable latency; expected enable/done/err events are queued up front
// and a monitor compares every output event against the queue.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int K_ARK = 0, K_SB = 1, K_SR = 2, K_MC = 3, K_DONE = 4, K_ERR = 5;

    logic       clk = 1'b0;
    logic       g_rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sb_done = 1'b0, sr_done = 1'b0, mc_done = 1'b0, ark_done = 1'b0;
    logic       sb_en, sr_en, mc_en, ark_en;
    logic [3:0] round_idx;
    logic       last_round, busy, done, err;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .g_rst(g_rst), .start(start), .abort(abort),
        .sb_done(sb_done), .sr_done(sr_done), .mc_done(mc_done), .ark_done(ark_done),
        .sb_en(sb_en), .sr_en(sr_en), .mc_en(mc_en), .ark_en(ark_en),
        .round_idx(round_idx), .last_round(last_round),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int cyc;
        int rnd;
    } ev_t;

    ev_t   exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    lat = 1;
    bit    hold_sr = 1'b0;
    int    stray_mc = -100;
    int    due[4];
    int    en_cnt[4];
    int    done_cnt = 0;
    int    last_done_cyc = -1;
    string kname[6] = '{"ark_en", "sb_en", "sr_en", "mc_en", "done", "err"};

    // Cycle N is the interval after rising edge N
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input int r, input int limit);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.rnd  = r;
        if (c <= limit) exp_q.push_back(e);
    endtask

    // Expected event train for a start in cycle s with stage latency l
    task automatic gen(input int s, input int l, input int limit);
        int c;
        c = s + 1;
        push(K_ARK, c, 0, limit);
        c += l + 1;
        for (int r = 1; r <= NR; r++) begin
            push(K_SB, c, r, limit);
            c += l + 1;
            push(K_SR, c, r, limit);
            c += l + 1;
            if (r < NR) begin
                push(K_MC, c, r, limit);
                c += l + 1;
            end
            push(K_ARK, c, r, limit);
            c += l + 1;
        end
        push(K_DONE, c, NR, limit);
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 4; k++) en_cnt[k] = 0;
        done_cnt = 0;
        last_done_cyc = -1;
    endtask

    task automatic do_start(output int s);
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen, next %s at cycle %0d",
                     nm, exp_q.size(), kname[exp_q[0].kind], exp_q[0].cyc);
            exp_q.delete();
        end
    endtask

    // Stage models: each done pulses lat cycles after its enable
    initial begin
        for (int k = 0; k < 4; k++) due[k] = -100;
        forever begin
            @(negedge clk);
            if (!g_rst) begin
                if (ark_en) due[0] = cyc + lat;
                if (sb_en)  due[1] = cyc + lat;
                if (sr_en)  due[2] = cyc + lat;
                if (mc_en)  due[3] = cyc + lat;
            end
            @(posedge clk);
            #1;
            ark_done = (cyc == due[0]);
            sb_done  = (cyc == due[1]);
            sr_done  = (cyc == due[2]) && !hold_sr;
            mc_done  = (cyc == due[3]) || (cyc == stray_mc);
        end
    end

    // Monitor: every asserted enable/done/err must match the head of the queue
    initial forever begin : mon
        logic [5:0] v;
        ev_t        e;
        @(negedge clk);
        if (!g_rst) begin
            v = {err, done, mc_en, sr_en, sb_en, ark_en};
            for (int k = 0; k < 6; k++) begin
                if (v[k]) begin
                    if (k < 4) en_cnt[k]++;
                    if (k == K_DONE) begin
                        done_cnt++;
                        last_done_cyc = cyc;
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected %s in cycle %0d round %0d", kname[k], cyc, round_idx);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.cyc != cyc || (k < 4 && e.rnd != int'(round_idx))) begin
                            errors++;
                            $display("FAIL event: got %s cycle %0d round %0d, expected %s cycle %0d round %0d",
                                     kname[k], cyc, round_idx, kname[e.kind], e.cyc, e.rnd);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

    initial begin
        int s;

        // Reset state
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en", {ark_en, sb_en, sr_en, mc_en}, 0);
        chk("rst_round_idx", round_idx, 0);
        chk("rst_last_round", last_round, 0);
        g_rst = 1'b0;
        tick();

        // Nominal run, 1-cycle stages
        lat = 1;
        clear_stats();
        gen(cyc, 1, 1 << 30);
        do_start(s);
        while (cyc < s + 40) tick();
        chk("nom_busy_mid", busy, 1);
        drain("nom_drain", 200);
        chk("nom_done_cycle", last_done_cyc - s, 81);
        chk("nom_ark_cnt", en_cnt[K_ARK], 11);
        chk("nom_sb_cnt", en_cnt[K_SB], 10);
        chk("nom_sr_cnt", en_cnt[K_SR], 10);
        chk("nom_mc_cnt", en_cnt[K_MC], 9);
        tick();
        chk("nom_idle_busy", busy, 0);
        chk("nom_hold_round", round_idx, 10);
        chk("nom_last_round", last_round, 1);
        repeat (3) tick();

        // Variable latency, 3-cycle stages
        lat = 3;
        clear_stats();
        gen(cyc, 3, 1 << 30);
        do_start(s);
        drain("lat3_drain", 400);
        chk("lat3_done_cycle", last_done_cyc - s, 161);
        chk("lat3_ark_cnt", en_cnt[K_ARK], 11);
        chk("lat3_mc_cnt", en_cnt[K_MC], 9);
        repeat (3) tick();

        // Abort in cycle 20, coinciding with sb_done
        lat = 1;
        clear_stats();
        gen(cyc, 1, cyc + 20);
        do_start(s);
        while (cyc < s + 20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_round", round_idx, 3);
        chk("abort_en", {ark_en, sb_en, sr_en, mc_en}, 0);
        drain("abort_drain", 5);
        repeat (5) tick();
        chk("abort_no_done", done_cnt, 0);
        clear_stats();
        gen(cyc, 1, 1 << 30);
        do_start(s);
        drain("restart_drain", 200);
        chk("restart_done_cycle", last_done_cyc - s, 81);
        repeat (3) tick();

        // Reset in cycle 40 of a run
        clear_stats();
        gen(cyc, 1, cyc + 39);
        do_start(s);
        while (cyc < s + 40) tick();
        g_rst = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_en", {ark_en, sb_en, sr_en, mc_en}, 0);
        chk("mrst_round", round_idx, 0);
        chk("mrst_flags", {last_round, done, err}, 0);
        drain("mrst_drain", 2);
        repeat (2) tick();
        g_rst = 1'b0;
        tick();
        clear_stats();
        gen(cyc, 1, 1 << 30);
        do_start(s);
        drain("post_rst_drain", 200);
        chk("post_rst_done_cycle", last_done_cyc - s, 81);
        repeat (3) tick();

        // Start held through the run plus a stray mc_done during SB
        clear_stats();
        s = cyc;
        stray_mc = s + 4;
        gen(s, 1, 1 << 30);
        start = 1'b1;
        while (cyc < s + 81) tick();
        start = 1'b0;
        drain("spur_drain", 50);
        repeat (4) tick();
        chk("spur_done_cycle", last_done_cyc - s, 81);
        chk("spur_done_pulses", done_cnt, 1);
        chk("spur_mc_cnt", en_cnt[K_MC], 9);
        stray_mc = -100;

        // Withheld sr_done
        clear_stats();
        hold_sr = 1'b1;
        s = cyc;
        push(K_ARK, s + 1, 0, 1 << 30);
        push(K_SB, s + 3, 1, 1 << 30);
        push(K_SR, s + 5, 1, 1 << 30);
`ifdef AES_CTRL_TIMEOUT_EN
        push(K_ERR, s + 22, 0, 1 << 30);
        do_start(s);
        while (cyc < s + 23) tick();
        chk("wdog_busy", busy, 0);
        chk("wdog_err_pulse", err, 0);
        drain("wdog_drain", 5);
        repeat (4) tick();
        chk("wdog_no_done", done_cnt, 0);
`else
        do_start(s);
        while (cyc < s + 40) tick();
        chk("nowdog_busy", busy, 1);
        chk("nowdog_err", err, 0);
        chk("nowdog_round", round_idx, 1);
        drain("nowdog_drain", 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("nowdog_abort_busy", busy, 0);
`endif
        hold_sr = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning the number of cipher rounds (AES-128).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum wait for a stage done, used only under REQ-027.
REQ-003 SHALL have port clk, input, 1, the clock; reset g_rst is asynchronous and active-high; the clock is clk.
REQ-004 SHALL have port g_rst, input, 1, the asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a request to begin one block encryption.
REQ-006 SHALL have port abort, input, 1, a synchronous cancel of the current operation.
REQ-007 SHALL have ports sb_done, sr_done, mc_done, ark_done, each input, 1, the completion flag of SubBytes, ShiftRows, MixColumns and AddRoundKey.
REQ-008 SHALL have ports sb_en, sr_en, mc_en, ark_en, each output, 1, the stage enable.
REQ-009 SHALL have port round_idx, output, 4, the current round number (0 = initial key add).
REQ-010 SHALL have port last_round, output, 1, high while round_idx == NUM_ROUNDS.
REQ-011 SHALL have ports busy, done and err, each output, 1: operation in progress, completion pulse, and timeout pulse.

Function
REQ-012 SHALL drive all outputs from registers; cycle N denotes the interval after rising edge N.
REQ-013 SHALL implement the states IDLE, ARK0, SB, SR, MC, ARK and FIN.
REQ-014 SHALL leave IDLE for ARK0 when start is sampled high; start is ignored in every other state.
REQ-015 SHALL pulse the enable of a stage high for exactly the first cycle of that stage's state, then wait with all enables low.
REQ-016 SHALL ignore the done input of the active stage during the enable cycle, sample it from the following cycle, and ignore the done inputs of non-active stages.
REQ-017 SHALL, on the active done sampled high, transition ARK0->SB (round_idx=1), SB->SR, SR->MC when round_idx<NUM_ROUNDS, SR->ARK when round_idx==NUM_ROUNDS, MC->ARK, ARK->SB with round_idx+1 when round_idx<NUM_ROUNDS, and ARK->FIN when round_idx==NUM_ROUNDS.
REQ-018 SHALL hold done high for exactly one cycle in FIN, then return to IDLE.
REQ-019 SHALL hold busy high in every state other than IDLE and FIN.
REQ-020 SHALL hold round_idx at NUM_ROUNDS after completion until the next start, which resets it to 0.
REQ-021 SHALL, with 1-cycle stages and start high in cycle 0, produce enables in odd cycles 1..79 (40 stages), done in cycle 81, and busy during cycles 1..80.
REQ-022 SHALL, on abort sampled high in any state, enter IDLE the next cycle with enables, busy and done low, round_idx unchanged, and no done or err pulse.
REQ-023 SHALL give abort priority when abort and start are high together in IDLE, so the block stays in IDLE.
REQ-024 SHALL give abort priority when abort and a stage done are sampled in the same cycle.

Reset
REQ-025 SHALL, on g_rst high, immediately force state IDLE, all enables, busy, done, err and last_round to 0, round_idx to 0, and the timeout counter to 0, including mid-operation.
REQ-026 SHALL resume from IDLE on the first clock edge after g_rst deasserts.

Configuration
REQ-027 SHALL compile the stage watchdog in when macro AES_CTRL_TIMEOUT_EN is defined: while waiting, a counter increments each cycle; if it reaches TIMEOUT_CYCLES without the active done, err pulses high for one cycle and the FSM enters IDLE with no done pulse.
REQ-028 SHALL, without AES_CTRL_TIMEOUT_EN, omit the counter, tie err to 0, and wait indefinitely for done.

Verification
REQ-029 SHALL verify a nominal run: start in cycle 0 with stage models replying done 1 cycle after enable -> ark_en in cycle 1, mc_en never in round 10, done in cycle 81, and enable counts ark=11, sb=10, sr=10, mc=9.
REQ-030 SHALL verify variable latency: stages reply after 3 cycles -> the same enable order and counts, with each next enable 1 cycle after done.
REQ-031 SHALL verify abort: abort in cycle 20 -> IDLE in cycle 21, busy=0, no done; a restart then completes normally.
REQ-032 SHALL verify reset mid-run: g_rst at cycle 40 -> all outputs 0 immediately; a start after release gives done 81 cycles later.
REQ-033 SHALL verify spurious inputs: start held high during a run and stray mc_done during SB -> no effect, and a single done pulse.
REQ-034 SHALL verify the watchdog: with AES_CTRL_TIMEOUT_EN defined and sr_done withheld -> err pulse 16 cycles after the wait starts, then IDLE; without the macro -> err stays 0 and busy stays 1.
